mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu.sv | 129 ++++++++++++
 tb/tb_mdu.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latency defaults, HI/LO width.
// Latency: n/a (definitions only).
// Backpressure: n/a; consumers (mdu, controller, hazard unit) import this package.
package mdu_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } mdu_op_e;

endpackage

// File: rtl/mdu.sv
// Purpose: MIPS-style HI/LO multiply/divide unit; MULT/MULTU/DIV/DIVU run in the background,
//   MTHI/MTLO write immediately.
// Latency: mul MULT_CYCLES, div DIV_CYCLES (HI/LO valid the first cycle busy is low); MTHI/MTLO 0.
// Backpressure: busy high while running; starts seen while busy are dropped (the hazard unit stalls).
// Ports: clk, reset (async active-low), start/op/A/B request, busy/hi/lo status and results.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;   // low two bits of a mul/div op: [1]=divide, [0]=unsigned

  // ---------------------------------------------------------------------------
  // Datapath, evaluated from the latched operands only, so A/B/op may change
  // freely while the operation is in flight.
  // ---------------------------------------------------------------------------
  logic              sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, uq, ur, quot, rem;

  assign sgn   = ~op_q[0];
  assign a_ext = {{XLEN{sgn & a_q[XLEN-1]}}, a_q};
  assign b_ext = {{XLEN{sgn & b_q[XLEN-1]}}, b_q};
  // Low 2*XLEN bits of the product of sign/zero-extended operands is exact for both flavours.
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes and fix signs afterwards. This also makes
  // 0x80000000 / -1 wrap to 0x80000000 rem 0 without relying on signed overflow.
  assign a_neg = sgn & a_q[XLEN-1];
  assign b_neg = sgn & b_q[XLEN-1];
  assign a_mag = a_neg ? (~a_q + 1'b1) : a_q;
  assign b_mag = b_neg ? (~b_q + 1'b1) : b_q;
  assign uq    = (b_mag == '0) ? '0 : (a_mag / b_mag);
  assign ur    = (b_mag == '0) ? '0 : (a_mag % b_mag);
  assign quot  = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
  assign rem   = a_neg ? (~ur + 1'b1) : ur;   // remainder follows the dividend's sign

  // ---------------------------------------------------------------------------
  // Next-state logic. IDLE is cnt==0, RUN is cnt!=0.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;

    if (cnt_q != '0) begin
      // RUN: any start is ignored; commit the result on the 1->0 step.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        if (op_q[1]) begin
          // Divide by zero leaves HI/LO untouched.
          if (b_q != '0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end
      end
    end else if (start) begin
      unique case (mdu_op_e'(op))
        OP_MULT, OP_MULTU: begin
          a_d   = A;
          b_d   = B;
          op_d  = op[1:0];
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          a_d   = A;
          b_d   = B;
          op_d  = op[1:0];
          cnt_d = CNT_W'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;   // 6/7 are no-ops
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);   // registered copy of (cnt != 0)
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Testbench for mdu: directed vectors with literal expectations plus a per-cycle
// comparison against a behavioural HI/LO model.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] A     = 32'd0;
  logic [31:0] B     = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural result of a mul/div op, from plain 64-bit arithmetic.
  function automatic void model_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] rh, output logic [31:0] rl, output bit wr);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    rh = 32'd0;
    rl = 32'd0;
    wr = 1'b1;
    case (o)
      3'd0: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
      3'd1: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      3'd2: if (b == 32'd0) wr = 1'b0;
            else begin sq = sa / sb; sr = sa % sb; rl = sq[31:0]; rh = sr[31:0]; end
      default: if (b == 32'd0) wr = 1'b0;
            else begin uq = ua / ub; ur = ua % ub; rl = uq[31:0]; rh = ur[31:0]; end
    endcase
  endfunction

  // Behavioural model: remaining busy cycles and the pending result.
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  bit          m_pwr = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_pwr  = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pwr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (start) begin
      if (op < 3'd4) begin
        model_result(op, A, B, m_phi, m_plo, m_pwr);
        m_left = (op < 3'd2) ? 5 : 10;
      end else if (op == 3'd4) begin
        m_hi = A;
      end else if (op == 3'd5) begin
        m_lo = A;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    check("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    check("cyc_hi", hi, m_hi);
    check("cyc_lo", lo, m_lo);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    if (n >= 40) check({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int ncyc, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(o, a, b);
    wait_idle(nm, n);
    check({nm, "_cycles"}, n, ncyc);
    check({nm, "_hi"}, hi, ehi);
    check({nm, "_lo"}, lo, elo);
  endtask

  initial begin
    int n;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    run_op("mult_neg",  OP_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
    run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_zero", OP_DIVU,  32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    run_op("divu_pos",  OP_DIVU,  32'd100,      32'd7,        10, 32'd2,        32'd14);

    // MTLO / MTHI in IDLE: zero latency, busy stays low
    issue(OP_MTLO, 32'h1234, 32'd0);
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    tick();
    check("mtlo_busy2", {31'd0, busy}, 32'd0);
    issue(OP_MTHI, 32'hCAFE, 32'd0);
    check("mthi_hi", hi, 32'hCAFE);

    // Starts during RUN are dropped
    issue(OP_MULT, 32'd5, 32'd6);
    tick();
    issue(OP_MTHI, 32'hDEAD, 32'd0);
    issue(OP_MULTU, 32'd9, 32'd9);
    wait_idle("mthi_run", n);
    check("mthi_run_hi", hi, 32'd0);
    check("mthi_run_lo", lo, 32'd30);

    // Ops 6 and 7 change nothing
    issue(OP_NOP6, 32'h1111, 32'h2222);
    issue(OP_NOP7, 32'h3333, 32'h4444);
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", hi, 32'd0);
    check("nop_lo", lo, 32'd30);

    // Operands wander during RUN; result uses the start-edge values
    issue(OP_MULT, 32'd16, 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) begin
      A  = $urandom;
      B  = $urandom;
      op = 3'($urandom_range(0, 7));
      tick();
    end
    check("wander_hi", hi, 32'hFFFFFFFF);
    check("wander_lo", lo, 32'hFFFFFFF0);

    // Reset in the middle of a divide
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    run_op("post_rst_mult", OP_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
